phase_bank: RTL and testbench

- Upstream configuration stage for the per-transducer phase-offset clock channels.
- Parses a byte-command stream from the host UART receiver.
- Holds shadow and active per-channel offsets, per-channel output enables and the shared divide value.
- On commit, drives a timed re-phase pulse so every channel reloads its offset from a common instant, keeping the array phase-coherent.

---
 rtl/phase_bank_pkg.sv | 24 ++
 rtl/phase_bank_resync.sv | 48 ++++
 rtl/phase_bank.sv | 246 ++++++++++++++++++++++++
 tb/tb_phase_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/phase_bank_pkg.sv
// Shared definitions for the phase_bank command parser: opcodes, parser
// states and the header channel-field width.
package phase_bank_pkg;

    localparam int CH_FIELD_W = 6;

    localparam logic [1:0] OP_SET_OFFSET = 2'b00;
    localparam logic [1:0] OP_SET_OE     = 2'b01;
    localparam logic [1:0] OP_COMMIT     = 2'b10;
    localparam logic [1:0] OP_SET_DIVIDE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PAY_HI = 2'b01,
        ST_PAY_LO = 2'b10,
        ST_RESYNC = 2'b11
    } state_t;

    // True when a header channel field addresses an implemented channel.
    function automatic logic ch_in_range(input logic [CH_FIELD_W-1:0] ch, input int nch);
        ch_in_range = (int'(ch) < nch);
    endfunction

endpackage

// File: rtl/phase_bank_resync.sv
// Re-phase pulse generator: holds rephase_n low for RESYNC_CYCLES clocks after
// a load (or after reset release) and flags the final low cycle on done.
module phase_bank_resync #(
    parameter int RESYNC_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic rephase_n,
    output logic done
);

    localparam int CW = $clog2(RESYNC_CYCLES + 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          rephase_n_r;
    logic          done_r;

    // Next count: reload on request, otherwise run down to zero and hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = CW'(RESYNC_CYCLES);
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_nxt_s = cnt_r - CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and strobe registers; reset starts a full pulse so channels release together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r       <= CW'(RESYNC_CYCLES);
            rephase_n_r <= 1'b0;
            done_r      <= (RESYNC_CYCLES == 1);
        end else begin
            cnt_r       <= cnt_nxt_s;
            rephase_n_r <= (cnt_nxt_s == {CW{1'b0}});
            done_r      <= (cnt_nxt_s == CW'(1));
        end
    end

    assign rephase_n = rephase_n_r;
    assign done      = done_r;

endmodule

// File: rtl/phase_bank.sv
// Byte-command parser holding shadow/active channel offsets, output enables and
// the shared divide. Optional partial-frame timeout: PHASE_BANK_TIMEOUT_EN.
module phase_bank
    import phase_bank_pkg::*;
#(
    parameter int NCH            = 16,
    parameter int OFFSET_WIDTH   = 11,
    parameter int DIVIDE_RESET   = 624,
    parameter int RESYNC_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic [NCH*OFFSET_WIDTH-1:0] offsets,
    output logic [NCH-1:0]              oe,
    output logic [OFFSET_WIDTH-2:0]     divide,
    output logic                        rephase_n,
    output logic                        busy,
    output logic                        err
);

    localparam int OW = OFFSET_WIDTH;
    localparam int DW = OFFSET_WIDTH - 1;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [1:0]              op_r;
    logic [CH_FIELD_W-1:0]   ch_r;
    logic [7:0]              hi_r;
    logic [OW-1:0]           shadow_r [NCH];
    logic [DW-1:0]           shadow_div_r;
    logic [DW-1:0]           divide_r;
    logic [NCH*OW-1:0]       offsets_r;
    logic [NCH-1:0]          oe_r;
    logic                    err_r;
    logic                    rx_ready_r;
    logic                    busy_r;

    logic                    hs_s;
    logic [15:0]             val_s;
    logic [OW-1:0]           off_s;
    logic [DW-1:0]           div_s;
    logic                    wr_off_s;
    logic                    wr_oe_s;
    logic                    wr_div_s;
    logic                    commit_s;
    logic                    set_err_s;
    logic                    clr_err_s;
    logic                    rs_done_s;
    logic                    timeout_s;
    logic                    unused_val_s;

    assign hs_s         = rx_valid && rx_ready_r;
    assign val_s        = {hi_r, rx_data};
    assign off_s        = val_s[OW-1:0];
    assign div_s        = val_s[DW-1:0];
    assign unused_val_s = ^val_s;

`ifdef PHASE_BANK_TIMEOUT_EN
    logic [31:0] to_cnt_r;

    // Idle-time counter for a partially received frame; any handshake restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= 32'd0;
        end else if (hs_s || (state_r == ST_IDLE) || (state_r == ST_RESYNC)) begin
            to_cnt_r <= 32'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end
    end

    assign timeout_s = ((state_r == ST_PAY_HI) || (state_r == ST_PAY_LO)) && !hs_s &&
                       (to_cnt_r == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Parser next state and write/commit/error decisions for this cycle.
    always_comb begin
        state_nxt_s = state_r;
        wr_off_s    = 1'b0;
        wr_oe_s     = 1'b0;
        wr_div_s    = 1'b0;
        commit_s    = 1'b0;
        set_err_s   = 1'b0;
        clr_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    case (rx_data[7:6])
                        OP_SET_OFFSET, OP_SET_DIVIDE: state_nxt_s = ST_PAY_HI;
                        OP_SET_OE:                    state_nxt_s = ST_PAY_LO;
                        OP_COMMIT: begin
                            if (rx_data[5:0] == 6'd0) begin
                                commit_s    = 1'b1;
                                state_nxt_s = ST_RESYNC;
                            end else if (rx_data[5:0] == 6'd1) begin
                                clr_err_s = 1'b1;
                            end else begin
                                set_err_s = 1'b1;
                            end
                        end
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PAY_HI: begin
                if (hs_s) begin
                    state_nxt_s = ST_PAY_LO;
                end else begin
                    state_nxt_s = ST_PAY_HI;
                end
            end
            ST_PAY_LO: begin
                if (hs_s) begin
                    state_nxt_s = ST_IDLE;
                    case (op_r)
                        OP_SET_OFFSET: begin
                            // Offset counter start may not exceed the divide it counts against.
                            if (ch_in_range(ch_r, NCH) && (off_s[DW-1:0] <= shadow_div_r)) begin
                                wr_off_s = 1'b1;
                            end else begin
                                set_err_s = 1'b1;
                            end
                        end
                        OP_SET_OE: begin
                            if (ch_in_range(ch_r, NCH)) begin
                                wr_oe_s = 1'b1;
                            end else begin
                                set_err_s = 1'b1;
                            end
                        end
                        OP_SET_DIVIDE: begin
                            if (div_s != {DW{1'b0}}) begin
                                wr_div_s = 1'b1;
                            end else begin
                                set_err_s = 1'b1;
                            end
                        end
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_PAY_LO;
                end
            end
            ST_RESYNC: begin
                if (rs_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESYNC;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        if (timeout_s) begin
            state_nxt_s = ST_IDLE;
            set_err_s   = 1'b1;
        end else begin
            set_err_s   = set_err_s;
        end
    end

    // Parser state, frame capture registers and handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_RESYNC;
            op_r       <= 2'b00;
            ch_r       <= {CH_FIELD_W{1'b0}};
            hi_r       <= 8'h00;
            err_r      <= 1'b0;
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            rx_ready_r <= (state_nxt_s != ST_RESYNC);
            busy_r     <= (state_nxt_s == ST_RESYNC);
            if (hs_s && (state_r == ST_IDLE)) begin
                op_r <= rx_data[7:6];
                ch_r <= rx_data[5:0];
            end
            if (hs_s && (state_r == ST_PAY_HI)) begin
                hi_r <= rx_data;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (clr_err_s) begin
                err_r <= 1'b0;
            end
        end
    end

    // Shadow/active configuration; active copies move only on commit, oe acts at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_r[i] <= {OW{1'b0}};
            end
            shadow_div_r <= DW'(DIVIDE_RESET);
            divide_r     <= DW'(DIVIDE_RESET);
            offsets_r    <= {(NCH*OW){1'b0}};
            oe_r         <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_off_s && (ch_r == CH_FIELD_W'(i))) begin
                    shadow_r[i] <= off_s;
                end
                if (wr_oe_s && (ch_r == CH_FIELD_W'(i))) begin
                    oe_r[i] <= rx_data[0];
                end
                if (commit_s) begin
                    offsets_r[i*OW +: OW] <= shadow_r[i];
                end
            end
            if (wr_div_s) begin
                shadow_div_r <= div_s;
            end
            if (commit_s) begin
                divide_r <= shadow_div_r;
            end
        end
    end

    phase_bank_resync #(
        .RESYNC_CYCLES (RESYNC_CYCLES)
    ) u_resync (
        .clk       (clk),
        .rst       (rst),
        .load      (commit_s),
        .rephase_n (rephase_n),
        .done      (rs_done_s)
    );

    assign rx_ready = rx_ready_r;
    assign offsets  = offsets_r;
    assign oe       = oe_r;
    assign divide   = divide_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule

// File: tb/tb_phase_bank.sv
// Self-checking bench for phase_bank: directed frames plus random frames,
// compared against a frame-level model of the configuration state.
module tb_phase_bank;

    localparam int NCH = 16;
    localparam int OW  = 11;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [NCH*OW-1:0] offsets;
    logic [NCH-1:0]    oe;
    logic [OW-2:0]     divide;
    logic              rephase_n;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;

    int             m_shadow [NCH];
    int             m_active [NCH];
    logic [NCH-1:0] m_oe;
    int             m_sdiv;
    int             m_adiv;
    logic           m_err;

    phase_bank dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .offsets   (offsets),
        .oe        (oe),
        .divide    (divide),
        .rephase_n (rephase_n),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_oe   = '0;
        m_sdiv = 624;
        m_adiv = 624;
        m_err  = 1'b0;
    endtask

    function automatic int frame_len(input logic [7:0] hdr);
        case (hdr[7:6])
            2'b00:   return 3;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 3;
        endcase
    endfunction

    // Frame-level rules: apply one complete command to the model.
    task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int ch;
        int v;
        ch = int'(b0[5:0]);
        case (b0[7:6])
            2'b00: begin
                v = int'({b1, b2}) % 2048;
                if (ch >= NCH || (v % 1024) > m_sdiv) m_err = 1'b1;
                else m_shadow[ch] = v;
            end
            2'b01: begin
                if (ch >= NCH) m_err = 1'b1;
                else m_oe[ch] = b1[0];
            end
            2'b10: begin
                if (ch == 0) begin
                    m_active = m_shadow;
                    m_adiv   = m_sdiv;
                end else if (ch == 1) begin
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            default: begin
                v = int'({b1, b2}) % 1024;
                if (v == 0) m_err = 1'b1;
                else m_sdiv = v;
            end
        endcase
    endtask

    task automatic check_state(input string tag);
        logic [NCH*OW-1:0] exp_off;
        for (int i = 0; i < NCH; i++) begin
            exp_off[i*OW +: OW] = OW'(m_active[i]);
        end
        check({tag, "_offsets"}, 192'(offsets), 192'(exp_off));
        check({tag, "_divide"}, 192'(divide), 192'(m_adiv));
        check({tag, "_oe"}, 192'(oe), 192'(m_oe));
        check({tag, "_err"}, 192'(err), 192'(m_err));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 192'(n), 192'(0));
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Called just after the commit edge or reset release: measure the low pulse.
    task automatic measure_resync(input string tag);
        int lo;
        int bad;
        lo  = 0;
        bad = 0;
        while (rephase_n == 1'b0 && lo < 50) begin
            if (busy !== 1'b1 || rx_ready !== 1'b0) bad++;
            lo++;
            @(posedge clk);
            #1;
        end
        check({tag, "_pulse_len"}, 192'(lo), 192'(4));
        check({tag, "_busy_ready_during"}, 192'(bad), 192'(0));
        check({tag, "_busy_after"}, 192'(busy), 192'(0));
        check({tag, "_ready_after"}, 192'(rx_ready), 192'(1));
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        int len;
        len = frame_len(b0);
        send_byte(b0);
        if (len > 1) send_byte(b1);
        if (len > 2) send_byte(b2);
        model_apply(b0, b1, b2);
        check_state(tag);
        if (b0 == 8'h80) measure_resync(tag);
        else check({tag, "_ready"}, 192'(rx_ready), 192'(1));
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  hdr;
        int          sel;
        int          ch;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        check("reset_busy", 192'(busy), 192'(1));
        check("reset_ready", 192'(rx_ready), 192'(0));
        check("reset_rephase", 192'(rephase_n), 192'(0));
        rst = 1'b1;
        #1;
        measure_resync("release");
        check_state("released");

        do_frame("set3", 8'h03, 8'h04, 8'h38);
        do_frame("commit1", 8'h80, 8'h00, 8'h00);
        check("ch3_active", 192'(offsets[3*OW +: OW]), 192'(11'h438));
        do_frame("bad_off", 8'h02, 8'h02, 8'h71);
        do_frame("after_bad", 8'h02, 8'h01, 8'h00);
        do_frame("clr_err", 8'h81, 8'h00, 8'h00);
        do_frame("oe5", 8'h45, 8'h01, 8'h00);
        do_frame("oe16", 8'h50, 8'h01, 8'h00);
        do_frame("div499", 8'hC0, 8'h01, 8'hF3);
        do_frame("commit2", 8'h80, 8'h00, 8'h00);
        check("divide_499", 192'(divide), 192'(499));
        do_frame("div0", 8'hC0, 8'h00, 8'h00);
        do_frame("bad_commit", 8'h85, 8'h00, 8'h00);
        do_frame("commit3", 8'h80, 8'h00, 8'h00);
        check("divide_kept", 192'(divide), 192'(499));

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            ch  = $urandom_range(0, 19);
            w   = 16'($urandom);
            if (sel <= 3) begin
                hdr = {2'b00, 6'(ch)};
                w[10:0] = 11'($urandom_range(0, 1023)) | (11'($urandom_range(0, 1)) << 10);
            end else if (sel <= 5) begin
                hdr = {2'b01, 6'(ch)};
            end else if (sel == 6) begin
                hdr = {2'b11, 6'($urandom)};
                if ($urandom_range(0, 5) == 0) w[9:0] = 10'd0;
                else w[9:0] = 10'($urandom_range(1, 1023));
            end else begin
                sel = $urandom_range(0, 5);
                if (sel <= 3) hdr = 8'h80;
                else if (sel == 4) hdr = 8'h81;
                else hdr = {2'b10, 6'($urandom_range(2, 63))};
            end
            if (hdr[7:6] == 2'b01) do_frame("rand", hdr, w[7:0], 8'h00);
            else do_frame("rand", hdr, w[15:8], w[7:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
